// File: rtl/arb_prio_lock8.sv
// Eight-requester arbiter with a registered, locked grant.
// Supports fixed priority (bit 7 highest) or round-robin selection, plus an optional hold timeout.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no owner; arbitrates when enabled and any request is set
// BUSY    | grant held by gnt_id; hold_cnt counts the cycles of ownership
// RELEASE | one bus-turnaround cycle with gnt=0; timeout pulses here
module arb_prio_lock8 #(
    parameter int HOLD_MAX = 16,
    parameter int CW       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rr_mode,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam bit             HOLD_EN   = (HOLD_MAX != 0);
    localparam logic [CW-1:0]  HOLD_LAST = HOLD_EN ? CW'(HOLD_MAX - 1) : '0;

    state_t        state;
    logic [2:0]    last_id;
    logic [CW-1:0] hold_cnt;

    logic [2:0] base;
    logic [7:0] rot;
    logic [2:0] pos;
    logic [2:0] winner;
    logic       req_any;
    logic       owner_req;

    // Fixed mode is round-robin with the base pinned to 0. That gives the search order 7,6,...,0.
    assign base = rr_mode ? last_id : 3'd0;

    // rot[k] holds the requester that is k-th in the search order. The search starts at base-1.
    always_comb begin
        rot = '0;
        for (int k = 0; k < 8; k++) begin
            rot[k] = req[3'(base - 3'd1 - 3'(k))];
        end
    end

    always_comb begin
        pos = '0;
        for (int k = 7; k >= 0; k--) begin
            if (rot[k]) begin
                pos = 3'(k);
            end
        end
    end

    assign winner    = 3'(base - 3'd1 - pos);
    assign req_any   = |req;
    assign owner_req = req[gnt_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            gnt_vld  <= 1'b0;
            timeout  <= 1'b0;
            last_id  <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (en && req_any) begin
                        state    <= BUSY;
                        gnt      <= 8'd1 << winner;
                        gnt_id   <= winner;
                        gnt_vld  <= 1'b1;
                        last_id  <= winner;
                        hold_cnt <= '0;
                    end
                end
                BUSY: begin
                    // The conditions are checked in this order: request drop, then timeout, then disable.
                    if (!owner_req) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                    end else if (HOLD_EN && (hold_cnt == HOLD_LAST)) begin
                        state   <= RELEASE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                        timeout <= 1'b1;
                    end else if (!en) begin
                        state   <= IDLE;
                        gnt     <= '0;
                        gnt_id  <= '0;
                        gnt_vld <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                end
                RELEASE: begin
                    state   <= IDLE;
                    timeout <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    gnt     <= '0;
                    gnt_id  <= '0;
                    gnt_vld <= 1'b0;
                    timeout <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arb_prio_lock8.sv
// Scoreboard bench for arb_prio_lock8: two instances (HOLD_MAX 16 and 4) receive the same stimulus.
// A cycle-level ownership model predicts each output. A monitor checks every predicted cycle.
module tb_arb_prio_lock8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       rr_mode = 1'b0;
    logic [7:0] req = '0;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] id_a, id_b;
    logic       vld_a, vld_b, to_a, to_b;

    always #5 clk = ~clk;

    arb_prio_lock8 #(.HOLD_MAX(16), .CW(5)) dut_a (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .timeout(to_a)
    );

    arb_prio_lock8 #(.HOLD_MAX(4), .CW(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .rr_mode(rr_mode), .req(req),
        .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .timeout(to_b)
    );

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } out_t;

    // owner = -1 means nobody holds the grant. n = how many cycles the current owner has shown its grant.
    typedef struct {
        int owner;
        int n;
        bit rel;
        bit tout;
        int last;
    } mdl_t;

    out_t qa[$];
    out_t qb[$];
    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;
    int   cyc_no = 0;

    function automatic int pick(int base, logic [7:0] rq);
        for (int k = 1; k <= 8; k++) begin
            int idx;
            idx = (((base - k) % 8) + 8) % 8;
            if (rq[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic mdl_t step(mdl_t s, int hold, bit r, bit e, bit rr, logic [7:0] rq);
        mdl_t t;
        t = s;
        t.tout = 1'b0;
        if (r) begin
            t.owner = -1; t.n = 0; t.rel = 1'b0; t.last = 0;
        end else if (s.owner >= 0) begin
            if (!rq[s.owner]) begin
                t.owner = -1; t.rel = 1'b1;
            end else if (hold != 0 && s.n == hold) begin
                t.owner = -1; t.rel = 1'b1; t.tout = 1'b1;
            end else if (!e) begin
                t.owner = -1;
            end else begin
                t.n = s.n + 1;
            end
        end else if (s.rel) begin
            t.rel = 1'b0;
        end else if (e && rq != 8'h00) begin
            t.owner = pick(rr ? s.last : 0, rq);
            t.last  = t.owner;
            t.n     = 1;
        end
        return t;
    endfunction

    function automatic out_t expect_of(mdl_t s);
        out_t o;
        o.gnt = (s.owner >= 0) ? (8'd1 << s.owner) : 8'h00;
        o.id  = (s.owner >= 0) ? 3'(s.owner) : 3'd0;
        o.vld = (s.owner >= 0);
        o.to  = s.tout;
        return o;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit rr, input logic [7:0] rq);
        @(negedge clk);
        rst = r; en = e; rr_mode = rr; req = rq;
        @(posedge clk);
        ma = step(ma, 16, r, e, rr, rq);
        mb = step(mb, 4, r, e, rr, rq);
        qa.push_back(expect_of(ma));
        qb.push_back(expect_of(mb));
    endtask

    task automatic compare(input string name, input out_t got, input out_t exp_o);
        checks++;
        if (got !== exp_o) begin
            errors++;
            $display("FAIL %s cycle %0d: got gnt=%h id=%0d vld=%b to=%b, expected gnt=%h id=%0d vld=%b to=%b",
                     name, cyc_no, got.gnt, got.id, got.vld, got.to,
                     exp_o.gnt, exp_o.id, exp_o.vld, exp_o.to);
        end
        checks++;
        if (!$onehot0(got.gnt) || got.gnt !== (got.vld ? (8'd1 << got.id) : 8'h00)) begin
            errors++;
            $display("FAIL %s_invariant cycle %0d: gnt=%h id=%0d vld=%b", name, cyc_no, got.gnt, got.id, got.vld);
        end
    endtask

    initial begin : monitor
        out_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                compare("dut_a_h16", {gnt_a, id_a, vld_a, to_a}, ea);
            end
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                compare("dut_b_h4", {gnt_b, id_b, vld_b, to_b}, eb);
            end
        end
    end

    initial begin : stimulus
        logic [7:0] rnd_req;
        bit         rnd_rr;
        ma = '{owner: -1, n: 0, rel: 1'b0, tout: 1'b0, last: 0};
        mb = '{owner: -1, n: 0, rel: 1'b0, tout: 1'b0, last: 0};

        repeat (2) cyc(1, 0, 0, 8'h00);

        // Fixed priority: id 5 wins over id 2. When req 5 drops, id 2 is granted after the turnaround.
        repeat (3) cyc(0, 1, 0, 8'h24);
        repeat (6) cyc(0, 1, 0, 8'h04);
        repeat (3) cyc(0, 1, 0, 8'h00);

        // Fixed mode, all requests held: the grant times out and id 7 wins again.
        repeat (45) cyc(0, 1, 0, 8'hFF);
        repeat (3) cyc(0, 1, 0, 8'h00);

        // Round-robin starting from reset, all requests held.
        cyc(1, 1, 1, 8'h00);
        repeat (62) cyc(0, 1, 1, 8'hFF);
        repeat (3) cyc(0, 1, 1, 8'h00);

        // Disable while id 3 owns the grant, hold disabled, then re-enable.
        repeat (3) cyc(0, 1, 0, 8'h08);
        repeat (4) cyc(0, 0, 0, 8'h08);
        repeat (3) cyc(0, 1, 0, 8'h08);
        repeat (3) cyc(0, 1, 0, 8'h00);

        // id 1 drops its request in the same cycle the 4-cycle hold expires.
        repeat (4) cyc(0, 1, 0, 8'h02);
        repeat (3) cyc(0, 1, 0, 8'h00);

        // Reset while id 4 owns the grant, then round-robin restarts from 7.
        repeat (3) cyc(0, 1, 1, 8'h10);
        cyc(1, 1, 1, 8'h10);
        repeat (4) cyc(0, 1, 1, 8'hFF);

        rnd_req = 8'($urandom);
        rnd_rr  = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(7, 0) == 0) rnd_req[b] = ~rnd_req[b];
            end
            if ($urandom_range(63, 0) == 0) rnd_rr = ~rnd_rr;
            cyc(($urandom_range(499, 0) == 0), ($urandom_range(15, 0) != 0), rnd_rr, rnd_req);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_prio_lock8.md
Name: arb_prio_lock8

Overview:
- Eight-requester bus/resource arbiter built around an 8-to-3 highest-index priority selection.
- Grant is registered and locked until the owner drops its request, a hold timeout expires, or the block is disabled.
- Two selection modes: fixed priority (bit 7 highest) and round-robin, where the last owner drops to lowest priority.
- Sits in front of any shared single-owner resource; gnt_id drives the resource's source-select mux.

Parameters:
- HOLD_MAX, 16, maximum consecutive BUSY cycles per grant; 0 disables the timeout.
- CW, 5, hold-counter width; must satisfy 2^CW > HOLD_MAX.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  arbiter enable; low blocks new grants and revokes any current grant
- rr_mode  input  1  0 = fixed priority, 1 = round-robin; sampled only in IDLE
- req  input  8  request vector, one bit per requester, level-sensitive
- gnt  output  8  one-hot grant vector, registered
- gnt_id  output  3  binary index of the owner, valid when gnt_vld=1, else 0
- gnt_vld  output  1  a grant is active (equals |gnt)
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (rst); its polarity and synchronicity are fixed.
- Reset values: state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, timeout=0, last_id=0, hold_cnt=0. Reset wins over every other event, including mid-grant.
- States: IDLE, BUSY, RELEASE. All outputs are registered; there is no combinational path from req to gnt.
- IDLE:
  - If en=1 and req!=0, select a winner, go to BUSY, and assert gnt/gnt_id/gnt_vld at the next edge (1-cycle latency).
  - Otherwise stay in IDLE.
- Selection, fixed mode: highest set index wins (req=8'b0010_0100 -> id 5).
- Selection, round-robin mode:
  - Search order is last_id-1, last_id-2, ..., wrapping mod 8, with last_id itself checked last.
  - After reset (last_id=0) the order is 7,6,...,0, identical to fixed mode.
- last_id updates to the winner on every grant, in both modes.
- BUSY:
  - hold_cnt clears on entry and increments each BUSY cycle.
  - If req[gnt_id]=0, go to RELEASE (gnt cleared at the next edge).
  - Else if HOLD_MAX!=0 and hold_cnt==HOLD_MAX-1, go to RELEASE with timeout=1 for exactly that RELEASE cycle.
  - Else if en=0, go directly to IDLE with gnt cleared; timeout stays 0.
  - Priority when several apply in one cycle: request drop > timeout > en low.
  - Requests from other requesters never preempt the owner.
- RELEASE:
  - Exactly one cycle with gnt=0 (bus turnaround), then IDLE.
  - New arbitration happens in IDLE, so the minimum gap between two grants is 2 cycles with gnt=0.
- Grant duration: with continuous req, a grant lasts exactly HOLD_MAX cycles.
- A timed-out requester that keeps req high re-competes normally.
  - Fixed mode: it may win again.
  - RR mode: it has lowest priority.
- rr_mode changes while BUSY take effect at the next IDLE arbitration.
- Invariants: gnt is always zero or one-hot, and gnt==(gnt_vld << gnt_id).

Test Plan:
- Reset then req=8'h24, rr_mode=0, en=1 -> one cycle later gnt=8'h20, gnt_id=5, gnt_vld=1. Drop req[5] -> gnt=0 for 1 cycle (RELEASE), then IDLE, then gnt=8'h04, id 2.
- Fixed mode, req=8'hFF held, HOLD_MAX=16 -> id 7 granted for exactly 16 cycles, timeout=1 one cycle with gnt=0, then id 7 granted again.
- RR mode, req=8'hFF held, HOLD_MAX=4 -> grant ids 7,6,5,4,3,2,1,0,7 in sequence, each for 4 cycles, separated by 2 idle cycles.
- BUSY with owner id 3, drive en=0 -> gnt=0 at the next edge, timeout=0. While en=0 and req=8'h08, no grant. Set en=1 -> grant id 3 after 1 cycle.
- Owner id 1 drops req in the same cycle hold_cnt hits HOLD_MAX-1 -> RELEASE with timeout=0 (request drop wins). Owner id 4 with rst=1 asserted mid-BUSY -> all outputs 0 at the next edge, and the next RR arbitration uses order 7..0.
- Random req/en/rr_mode stimulus for 10k cycles -> gnt always zero or one-hot, gnt==(gnt_vld<<gnt_id), no grant change without an intervening cycle with gnt=0.
